// File: rtl/sync_detect.sv
// sync_detect: receive-side timing recovery for an h_sync/v_sync pair.
// Measures line length, sync widths and lines per frame. Declares lock
// once two consecutive frames match a clean reference. While locked, it
// regenerates active-area pixel coordinates.
module sync_detect #(
    parameter logic H_SYNC_POLARITY = 1'b1,
    parameter logic V_SYNC_POLARITY = 1'b1,
    parameter int   CNT_WIDTH       = 16,
    parameter int   SCREEN_WIDTH    = 800,
    parameter int   SCREEN_HEIGHT   = 600,
    parameter int   H_ACTIVE_OFFSET = 214,
    parameter int   V_ACTIVE_OFFSET = 27
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 h_sync,
    input  logic                 v_sync,
    output logic [CNT_WIDTH-1:0] line_length,
    output logic [CNT_WIDTH-1:0] hsync_width,
    output logic [CNT_WIDTH-1:0] frame_lines,
    output logic [CNT_WIDTH-1:0] vsync_lines,
    output logic                 locked,
    output logic                 on_screen,
    output logic [CNT_WIDTH-1:0] pixel_x,
    output logic [CNT_WIDTH-1:0] pixel_y
);

    // Counter limits and active-window bounds. The bounds carry one extra
    // bit so that offset + size cannot wrap inside the comparison.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] H_OFFSET = CNT_WIDTH'(H_ACTIVE_OFFSET);
    localparam logic [CNT_WIDTH-1:0] V_OFFSET = CNT_WIDTH'(V_ACTIVE_OFFSET);
    localparam logic [CNT_WIDTH:0]   H_START  = (CNT_WIDTH+1)'(H_ACTIVE_OFFSET);
    localparam logic [CNT_WIDTH:0]   H_STOP   = (CNT_WIDTH+1)'(H_ACTIVE_OFFSET + SCREEN_WIDTH);
    localparam logic [CNT_WIDTH:0]   V_START  = (CNT_WIDTH+1)'(V_ACTIVE_OFFSET);
    localparam logic [CNT_WIDTH:0]   V_STOP   = (CNT_WIDTH+1)'(V_ACTIVE_OFFSET + SCREEN_HEIGHT);

    // The lock level mirrors a saturating count of consecutive good frames.
    typedef enum logic [1:0] {
        LOCK_HUNT = 2'd0,
        LOCK_ONE  = 2'd1,
        LOCK_HELD = 2'd2
    } lock_state_t;

    logic                 h_n;
    logic                 v_n;
    logic                 h_q;
    logic                 h_q1;
    logic                 v_q;
    logic                 v_q1;
    logic                 h_rise;
    logic                 h_fall;
    logic                 v_rise;
    logic                 v_fall;
    logic [CNT_WIDTH-1:0] h_count;
    logic [CNT_WIDTH-1:0] v_count;
    logic [CNT_WIDTH-1:0] h_len_new;
    logic                 h_sat;
    logic                 v_sat;
    logic                 line_mismatch;
    logic                 bad_set;
    logic                 line_bad;
    logic                 frame_ok;
    logic                 h_in;
    logic                 v_in;
    lock_state_t          lock_state;
    lock_state_t          lock_next;

    // Normalise both syncs to active-high before any edge detection.
    assign h_n = ~(h_sync ^ H_SYNC_POLARITY);
    assign v_n = ~(v_sync ^ V_SYNC_POLARITY);

    // Two-stage capture of the normalised syncs for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q  <= 1'b0;
            h_q1 <= 1'b0;
            v_q  <= 1'b0;
            v_q1 <= 1'b0;
        end else begin
            h_q  <= h_n;
            h_q1 <= h_q;
            v_q  <= v_n;
            v_q1 <= v_q;
        end
    end

    assign h_rise = h_q & ~h_q1;
    assign h_fall = ~h_q & h_q1;
    assign v_rise = v_q & ~v_q1;
    assign v_fall = ~v_q & v_q1;

    // The measured length of the line that ends on this h_rise. The same
    // sum gives the sync width on h_fall. At saturation it wraps to zero,
    // which marks the measurement as invalid.
    assign h_len_new     = h_count + CNT_ONE;
    assign h_sat         = (h_count == CNT_MAX);
    assign v_sat         = (v_count == CNT_MAX);
    assign line_mismatch = h_rise && (h_len_new != line_length);
    assign bad_set       = line_mismatch | h_sat | v_sat;
    assign frame_ok      = (v_count == frame_lines) && !line_bad;

    // Pixel counter: restarts on each line start and otherwise saturates.
    // It also latches the line length and h_sync width.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_count     <= '0;
            line_length <= '0;
            hsync_width <= '0;
        end else begin
            if (h_rise) begin
                h_count     <= '0;
                line_length <= h_len_new;
            end else if (!h_sat) begin
                h_count     <= h_count + CNT_ONE;
            end
            if (h_fall) begin
                hsync_width <= h_len_new;
            end
        end
    end

    // Line counter: advances on line starts and restarts on frame starts.
    // A line start that coincides with the frame start is counted in the
    // new frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_count     <= '0;
            frame_lines <= '0;
            vsync_lines <= '0;
        end else begin
            if (v_rise) begin
                frame_lines <= v_count;
                v_count     <= h_rise ? CNT_ONE : '0;
            end else if (h_rise && !v_sat) begin
                v_count     <= v_count + CNT_ONE;
            end
            if (v_fall) begin
                vsync_lines <= v_count;
            end
        end
    end

    // Sticky per-frame error flag. It is evaluated at the frame start
    // before it clears, so a fault on the coincident line start is kept
    // for the new frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_bad <= 1'b0;
        end else if (v_rise) begin
            line_bad <= bad_set;
        end else if (bad_set) begin
            line_bad <= 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_state <= LOCK_HUNT;
        end else begin
            lock_state <= lock_next;
        end
    end

    // Lock transitions: any line fault or timeout drops back to hunting
    // immediately. Otherwise each good frame moves one step toward held.
    always_comb begin
        lock_next = lock_state;
        if (bad_set) begin
            lock_next = LOCK_HUNT;
        end else if (v_rise) begin
            if (!frame_ok) begin
                lock_next = LOCK_HUNT;
            end else begin
                case (lock_state)
                    LOCK_HUNT: lock_next = LOCK_ONE;
                    LOCK_ONE:  lock_next = LOCK_HELD;
                    LOCK_HELD: lock_next = LOCK_HELD;
                    default:   lock_next = LOCK_HUNT;
                endcase
            end
        end
    end

    assign locked = (lock_state == LOCK_HELD);

    // Active-window qualification and coordinates, taken from the counters.
    assign h_in      = ({1'b0, h_count} >= H_START) && ({1'b0, h_count} < H_STOP);
    assign v_in      = ({1'b0, v_count} >= V_START) && ({1'b0, v_count} < V_STOP);
    assign on_screen = locked && h_in && v_in;
    assign pixel_x   = h_count - H_OFFSET;
    assign pixel_y   = v_count - V_OFFSET;

endmodule

// File: tb/tb_sync_detect.sv
// tb_sync_detect: drives two sync_detect instances from a small sync
// generator. One instance sees active-high syncs, the other active-low.
// Each cycle the expected on_screen and coordinates are queued and then
// compared at the falling edge.
module tb_sync_detect;

    localparam int CW   = 12;
    localparam int HT   = 40;
    localparam int HS   = 4;
    localparam int HBP  = 6;
    localparam int HACT = 24;
    localparam int VT   = 20;
    localparam int VS   = 2;
    localparam int VBP  = 3;
    localparam int VACT = 12;
    localparam int HOFF = HS + HBP - 2;
    localparam int VOFF = VS + VBP;
    localparam int SAT  = (1 << CW) - 1;
    // Generator position of the first active pixel. The frame's first line
    // counts as line 1, so active lines begin one generator line early.
    localparam int GX0  = HS + HBP;
    localparam int GY0  = VOFF - 1;

    typedef struct {
        logic          on;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          h_sync;
    logic          v_sync;
    logic          hs_n;
    logic          vs_n;
    logic [CW-1:0] line_length [2];
    logic [CW-1:0] hsync_width [2];
    logic [CW-1:0] frame_lines [2];
    logic [CW-1:0] vsync_lines [2];
    logic [CW-1:0] pixel_x [2];
    logic [CW-1:0] pixel_y [2];
    logic          locked [2];
    logic          on_screen [2];

    exp_t sb[$];
    int   tests;
    int   fails;
    int   frame_no;
    int   cur_x;
    int   cur_y;
    bit   exp_lock;
    int   rise_f [2];
    int   rise_x [2];
    int   rise_y [2];
    int   fall_f [2];
    int   fall_x [2];
    int   fall_y [2];
    logic prev_lock [2];
    int   on_count;
    int   first_x;
    int   first_y;
    int   last_x;
    int   last_y;

    always #5 CLK = ~CLK;

    sync_detect #(
        .H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1), .CNT_WIDTH(CW),
        .SCREEN_WIDTH(HACT), .SCREEN_HEIGHT(VACT),
        .H_ACTIVE_OFFSET(HOFF), .V_ACTIVE_OFFSET(VOFF)
    ) dut_p (
        .CLK(CLK), .RST_N(RST_N), .h_sync(h_sync), .v_sync(v_sync),
        .line_length(line_length[0]), .hsync_width(hsync_width[0]),
        .frame_lines(frame_lines[0]), .vsync_lines(vsync_lines[0]),
        .locked(locked[0]), .on_screen(on_screen[0]),
        .pixel_x(pixel_x[0]), .pixel_y(pixel_y[0])
    );

    sync_detect #(
        .H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b0), .CNT_WIDTH(CW),
        .SCREEN_WIDTH(HACT), .SCREEN_HEIGHT(VACT),
        .H_ACTIVE_OFFSET(HOFF), .V_ACTIVE_OFFSET(VOFF)
    ) dut_n (
        .CLK(CLK), .RST_N(RST_N), .h_sync(hs_n), .v_sync(vs_n),
        .line_length(line_length[1]), .hsync_width(hsync_width[1]),
        .frame_lines(frame_lines[1]), .vsync_lines(vsync_lines[1]),
        .locked(locked[1]), .on_screen(on_screen[1]),
        .pixel_x(pixel_x[1]), .pixel_y(pixel_y[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pop this cycle's expectation and compare both instances. Also track
    // lock edges and per-frame on_screen statistics.
    task automatic sample_outputs();
        exp_t e;
        e = sb.pop_front();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("on_screen[%0d] x%0d y%0d", d, cur_x, cur_y),
                        32'(on_screen[d]), 32'(e.on));
            if (e.on) begin
                checkOutput($sformatf("pixel_x[%0d]", d), 32'(pixel_x[d]), 32'(e.x));
                checkOutput($sformatf("pixel_y[%0d]", d), 32'(pixel_y[d]), 32'(e.y));
            end
            if (locked[d] === 1'b1 && prev_lock[d] !== 1'b1 && rise_f[d] < 0) begin
                rise_f[d] = frame_no; rise_x[d] = cur_x; rise_y[d] = cur_y;
            end
            if (locked[d] !== 1'b1 && prev_lock[d] === 1'b1 && fall_f[d] < 0) begin
                fall_f[d] = frame_no; fall_x[d] = cur_x; fall_y[d] = cur_y;
            end
            prev_lock[d] = locked[d];
        end
        if (on_screen[0] === 1'b1) begin
            on_count++;
            if (first_x < 0) begin
                first_x = int'(pixel_x[0]); first_y = int'(pixel_y[0]);
            end
            last_x = int'(pixel_x[0]); last_y = int'(pixel_y[0]);
        end
    endtask

    // Drive one generator clock at position (x, y) and queue its expectation.
    // A negative x drives both syncs inactive.
    task automatic applyStimulus(input int x, input int y);
        exp_t e;
        @(posedge CLK);
        #1;
        h_sync = (x >= 0) && (x < HS);
        v_sync = (x >= 0) && (y < VS);
        hs_n   = ~h_sync;
        vs_n   = ~v_sync;
        cur_x  = x;
        cur_y  = y;
        e.on = exp_lock && (x >= GX0) && (x < GX0 + HACT) && (y >= GY0) && (y < GY0 + VACT);
        e.x  = CW'(x - GX0);
        e.y  = CW'(y - GY0);
        sb.push_back(e);
        @(negedge CLK);
        sample_outputs();
    endtask

    task automatic run_line(input int y, input int x0, input int len);
        for (int x = x0; x < len; x++) applyStimulus(x, y);
    endtask

    task automatic new_frame();
        frame_no++;
        on_count = 0;
        first_x  = -1;
        first_y  = -1;
        last_x   = -1;
        last_y   = -1;
    endtask

    // One full frame. The last line can be stretched by extra clocks.
    task automatic run_frame(input int extra);
        new_frame();
        for (int y = 0; y < VT; y++) run_line(y, 0, HT + ((y == VT - 1) ? extra : 0));
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s line_length[%0d]", tag, d), 32'(line_length[d]), 0);
            checkOutput($sformatf("%s hsync_width[%0d]", tag, d), 32'(hsync_width[d]), 0);
            checkOutput($sformatf("%s frame_lines[%0d]", tag, d), 32'(frame_lines[d]), 0);
            checkOutput($sformatf("%s vsync_lines[%0d]", tag, d), 32'(vsync_lines[d]), 0);
            checkOutput($sformatf("%s locked[%0d]", tag, d), 32'(locked[d]), 0);
            checkOutput($sformatf("%s on_screen[%0d]", tag, d), 32'(on_screen[d]), 0);
        end
    endtask

    task automatic check_meas(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s line_length[%0d]", tag, d), 32'(line_length[d]), HT);
            checkOutput($sformatf("%s hsync_width[%0d]", tag, d), 32'(hsync_width[d]), HS);
            checkOutput($sformatf("%s frame_lines[%0d]", tag, d), 32'(frame_lines[d]), VT);
            checkOutput($sformatf("%s vsync_lines[%0d]", tag, d), 32'(vsync_lines[d]), VS);
            checkOutput($sformatf("%s locked[%0d]", tag, d), 32'(locked[d]), 1);
        end
    endtask

    task automatic check_rise(input string tag, input int f);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s rise frame[%0d]", tag, d), 32'(rise_f[d]), 32'(f));
            checkOutput($sformatf("%s rise x[%0d]", tag, d), 32'(rise_x[d]), 2);
            checkOutput($sformatf("%s rise y[%0d]", tag, d), 32'(rise_y[d]), 0);
        end
    endtask

    task automatic check_frame_pixels(input string tag);
        checkOutput({tag, " on_count"}, 32'(on_count), HACT * VACT);
        checkOutput({tag, " first x"}, 32'(first_x), 0);
        checkOutput({tag, " first y"}, 32'(first_y), 0);
        checkOutput({tag, " last x"}, 32'(last_x), HACT - 1);
        checkOutput({tag, " last y"}, 32'(last_y), VACT - 1);
    endtask

    task automatic clear_edges();
        for (int d = 0; d < 2; d++) begin
            rise_f[d] = -1; rise_x[d] = -1; rise_y[d] = -1;
            fall_f[d] = -1; fall_x[d] = -1; fall_y[d] = -1;
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        frame_no = 0;
        exp_lock = 1'b0;
        RST_N    = 1'b0;
        h_sync   = 1'b0;
        v_sync   = 1'b0;
        hs_n     = 1'b1;
        vs_n     = 1'b1;
        for (int d = 0; d < 2; d++) prev_lock[d] = 1'b0;
        clear_edges();
        new_frame();

        // Reset state, then a long idle period with no sync activity.
        for (int i = 0; i < 3; i++) applyStimulus(-1, 0);
        check_zero("reset");
        RST_N = 1'b1;
        for (int i = 0; i < 5000; i++) applyStimulus(-1, 0);
        check_zero("idle");
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("idle pixel_x sat[%0d]", d), 32'(pixel_x[d]), 32'(SAT - HOFF));
            checkOutput($sformatf("idle pixel_y[%0d]", d), 32'(pixel_y[d]), 32'((SAT + 1) - VOFF));
        end

        // Start mid-frame. The first line start follows a saturated count.
        run_line(10, 5, HT);
        run_line(11, 0, HT);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("wrap line_length[%0d]", d), 32'(line_length[d]), 0);
        for (int y = 12; y < VT; y++) run_line(y, 0, HT);

        // Three full frames still hunting. Lock is expected at the fourth frame start.
        clear_edges();
        for (int i = 0; i < 3; i++) run_frame(0);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("pre-lock locked[%0d]", d), 32'(locked[d]), 0);
        exp_lock = 1'b1;
        run_frame(0);
        check_rise("acquire", frame_no);
        check_meas("acquire");
        check_frame_pixels("acquire");

        // Stretch the last line of a locked frame by one clock.
        clear_edges();
        run_frame(1);
        exp_lock = 1'b0;
        run_frame(0);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("stretch fall frame[%0d]", d), 32'(fall_f[d]), 32'(frame_no));
            checkOutput($sformatf("stretch fall x[%0d]", d), 32'(fall_x[d]), 2);
            checkOutput($sformatf("stretch fall y[%0d]", d), 32'(fall_y[d]), 0);
            checkOutput($sformatf("stretch locked[%0d]", d), 32'(locked[d]), 0);
        end
        for (int i = 0; i < 2; i++) run_frame(0);
        exp_lock = 1'b1;
        run_frame(0);
        check_rise("relock", frame_no);
        check_frame_pixels("relock");

        // Asynchronous reset in the middle of a locked frame.
        new_frame();
        for (int y = 0; y < 8; y++) run_line(y, 0, HT);
        run_line(8, 0, 11);
        #1;
        RST_N = 1'b0;
        #1;
        check_zero("async reset");
        exp_lock = 1'b0;
        run_line(8, 11, 14);
        RST_N = 1'b1;
        run_line(8, 14, HT);
        for (int y = 9; y < VT; y++) run_line(y, 0, HT);
        clear_edges();
        for (int i = 0; i < 3; i++) run_frame(0);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("post-reset locked[%0d]", d), 32'(locked[d]), 0);
        exp_lock = 1'b1;
        run_frame(0);
        check_rise("reacquire", frame_no);
        check_meas("reacquire");
        check_frame_pixels("reacquire");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_detect.md
Name: sync_detect

Overview:
- Receive-side counterpart of the VGA sync generator.
- Watches an h_sync/v_sync pair on the pixel clock domain and measures the line length, sync widths and lines per frame.
- Declares lock once timing is stable, then regenerates pixel coordinates and an on_screen qualifier.
- Used for video capture/loopback checks and to drive overlay logic from an external or internal timing source.

Parameters:
- H_SYNC_POLARITY, 1'b1, active level of h_sync input.
- V_SYNC_POLARITY, 1'b1, active level of v_sync input.
- CNT_WIDTH, 16, width of all counters and measurement outputs.
- SCREEN_WIDTH, 800, active pixels per line.
- SCREEN_HEIGHT, 600, active lines per frame.
- H_ACTIVE_OFFSET, 214, h_count value of first active pixel. Equals sync size + back porch − 2 detection cycles (128+88−2).
- V_ACTIVE_OFFSET, 27, v_count value of first active line. Equals v sync size + back porch (4+23).

Ports:
- CLK  input  1  pixel clock; only clock.
- RST_N  input  1  asynchronous, active-low reset.
- h_sync  input  1  horizontal sync, CLK-synchronous.
- v_sync  input  1  vertical sync, CLK-synchronous.
- line_length  output  CNT_WIDTH  clocks between consecutive h_sync leading edges.
- hsync_width  output  CNT_WIDTH  clocks h_sync held active.
- frame_lines  output  CNT_WIDTH  h_sync leading edges between consecutive v_sync leading edges.
- vsync_lines  output  CNT_WIDTH  lines v_sync held active.
- locked  output  1  timing stable.
- on_screen  output  1  current pixel inside active area and locked.
- pixel_x  output  CNT_WIDTH  active column; valid when on_screen.
- pixel_y  output  CNT_WIDTH  active row; valid when on_screen.

Behaviour:
- Reset: all registers and outputs 0, asynchronously on RST_N low. Release is synchronous to CLK.
- Input stage:
  - h_n = h_sync XNOR H_SYNC_POLARITY; v_n likewise (active = 1).
  - Register into h_q and v_q, plus delayed copies h_q1 and v_q1.
  - h_rise = h_q & ~h_q1; h_fall = ~h_q & h_q1; v_rise and v_fall defined the same way.
  - Detection latency: 2 CLK from input edge.
- h_count:
  - Increments each CLK and saturates at all-ones.
  - On h_rise: line_length <= h_count+1, h_count <= 0.
  - On h_fall: hsync_width <= h_count+1.
- v_count:
  - Increments on each h_rise and saturates at all-ones.
  - On v_rise: frame_lines <= v_count; v_count <= (h_rise ? 1 : 0). A coincident h_rise belongs to the new frame.
  - On v_fall: vsync_lines <= v_count.
- Lock:
  - line_bad is a sticky flag. It sets on any h_rise whose new length ≠ stored line_length. It sets on h_count or v_count saturation (timeout). It clears on v_rise, after evaluation.
  - On v_rise, frame_ok = (v_count == stored frame_lines) && !line_bad. If frame_ok, lock_cnt increments, saturating at 2; otherwise lock_cnt <= 0.
  - locked <= (next lock_cnt == 2), registered.
  - Any line_bad set or timeout clears locked and lock_cnt the cycle after.
  - From a clean source after reset: the first v_rise yields a partial frame, the second a mismatch vs partial, the third cnt=1, and the fourth locked=1.
- Coordinates (combinational from registers):
  - on_screen = locked && H_ACTIVE_OFFSET ≤ h_count < H_ACTIVE_OFFSET+SCREEN_WIDTH && V_ACTIVE_OFFSET ≤ v_count < V_ACTIVE_OFFSET+SCREEN_HEIGHT.
  - pixel_x = h_count − H_ACTIVE_OFFSET; pixel_y = v_count − V_ACTIVE_OFFSET (modulo 2^CNT_WIDTH). Don't-care when on_screen = 0.
- Wrap/timeouts:
  - Saturated counters hold at all-ones until the next edge.
  - Measurements are still latched (value all-ones+1 wraps to 0), which flags the input as invalid.
- Mid-operation reset: everything returns to 0 immediately; lock is re-acquired per the sequence above.

Test Plan:
- Reset release, h_sync/v_sync held inactive 70000 CLK -> outputs stay 0, locked=0, no counter rollover past all-ones.
- Drive from sync generator at defaults (1056/628, widths 128/4), 5 frames -> line_length=1056, hsync_width=128, frame_lines=628, vsync_lines=4, locked rises at 4th v_rise detection.
- Locked with generator -> on_screen pulse count per frame = 480000; first on_screen pixel coincides with generator on_screen, pixel_x=0/pixel_y=0; last is 799/599.
- While locked, stretch one line to 1057 clocks -> locked=0 the cycle after that h_rise, re-lock after 3 further clean frames.
- Polarity params 0 with inverted syncs -> identical measurements and lock timing as the polarity-1 case.
- Assert RST_N low mid-frame while locked -> all outputs 0 asynchronously; after release, lock reacquired at the 4th v_rise.
